ps2_key_tracker: RTL

//  Consumes the raw scan-code byte stream from the PS/2 keyboard receiver (one in_valid strobe per byte).

---
 rtl/ps2_pkg.sv | 29 ++
 rtl/ps2_key_tracker.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_pkg
//  Description : Shared constants for the PS/2 scan-code key tracker:
//                prefix/error byte values and the prefix-decoder state codes.
//  Revision    : 1.0  initial release
// ============================================================================
package ps2_pkg;

    // Scan-code bytes with special meaning in the make/break protocol
    localparam logic [7:0] PS2_EXT  = 8'hE0;   // extended-key prefix
    localparam logic [7:0] PS2_BRK  = 8'hF0;   // release (break) prefix
    localparam logic [7:0] PS2_ERR0 = 8'h00;   // keyboard buffer error / overrun
    localparam logic [7:0] PS2_ERRF = 8'hFF;   // keyboard buffer error / overrun

    // Prefix-decoder states
    localparam int          c_ST_W       = 2;
    localparam logic [1:0]  c_ST_IDLE    = 2'd0;   // no prefix pending
    localparam logic [1:0]  c_ST_BRK     = 2'd1;   // F0 seen
    localparam logic [1:0]  c_ST_EXT     = 2'd2;   // E0 seen
    localparam logic [1:0]  c_ST_EXT_BRK = 2'd3;   // E0 F0 seen

    // True for the two bytes a keyboard sends to report an internal error
    function automatic logic is_err_byte(input logic [7:0] b);
        return (b == PS2_ERR0) || (b == PS2_ERRF);
    endfunction

endpackage : ps2_pkg
`default_nettype wire

// File: rtl/ps2_key_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_key_tracker
//  Description : Decodes the PS/2 scan-code byte stream (E0/F0 prefixes) into
//                make/break events, tracks the single held key and counts
//                distinct presses while ignoring typematic repeats. A prefix
//                left dangling longer than TIMEOUT_CYC cycles is abandoned
//                with an error pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module ps2_key_tracker
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYC = 2000000,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic [7:0]       key_code,
    output logic             key_ext,
    output logic             key_down,
    output logic [CNT_W-1:0] press_cnt,
    output logic             evt_valid,
    output logic             evt_break,
    output logic [7:0]       evt_code,
    output logic             evt_ext,
    output logic             seq_err
);

    // Timer just wide enough to hold TIMEOUT_CYC-1
    localparam int                 c_TMR_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(TIMEOUT_CYC - 1);

    logic [c_ST_W-1:0]  r_state;
    logic [c_ST_W-1:0]  w_state_nxt;
    logic [c_TMR_W-1:0] r_timer;
    logic               w_timeout;
    logic               w_make;
    logic               w_break;
    logic               w_err;
    logic               w_ext;
    logic               w_repeat;
    logic               w_same_key;

    logic [7:0]         r_key_code;
    logic               r_key_ext;
    logic               r_key_down;
    logic [CNT_W-1:0]   r_press_cnt;
    logic               r_evt_valid;
    logic               r_evt_break;
    logic [7:0]         r_evt_code;
    logic               r_evt_ext;
    logic               r_seq_err;

    // A prefix has waited its full allowance without a follow-up byte
    assign w_timeout = (r_state != c_ST_IDLE) && (r_timer == c_TMR_LAST);

    // The incoming byte names the key currently recorded as held
    assign w_same_key = (r_key_ext == w_ext) && (r_key_code == in_data);

    // A make of the key already held is the keyboard's auto-repeat
    assign w_repeat   = r_key_down && w_same_key;

    // State register for the prefix decoder
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and event decode; a byte arriving on the timeout cycle wins
    always_comb begin
        w_state_nxt = r_state;
        w_make      = 1'b0;
        w_break     = 1'b0;
        w_err       = 1'b0;
        w_ext       = 1'b0;
        if (in_valid) begin
            case (r_state)
                c_ST_IDLE: begin
                    if (in_data == PS2_EXT) begin
                        w_state_nxt = c_ST_EXT;
                    end else if (in_data == PS2_BRK) begin
                        w_state_nxt = c_ST_BRK;
                    end else if (is_err_byte(in_data)) begin
                        w_err = 1'b1;
                    end else begin
                        w_make = 1'b1;
                    end
                end
                c_ST_EXT: begin
                    w_ext = 1'b1;
                    if (in_data == PS2_BRK) begin
                        w_state_nxt = c_ST_EXT_BRK;
                    end else if ((in_data == PS2_EXT) || is_err_byte(in_data)) begin
                        w_err       = 1'b1;
                        w_state_nxt = c_ST_IDLE;
                    end else begin
                        w_make      = 1'b1;
                        w_state_nxt = c_ST_IDLE;
                    end
                end
                c_ST_BRK, c_ST_EXT_BRK: begin
                    w_ext       = (r_state == c_ST_EXT_BRK);
                    w_state_nxt = c_ST_IDLE;
                    if ((in_data == PS2_EXT) || (in_data == PS2_BRK) || is_err_byte(in_data)) begin
                        w_err = 1'b1;
                    end else begin
                        w_break = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = c_ST_IDLE;
                end
            endcase
        end else if (w_timeout) begin
            w_err       = 1'b1;
            w_state_nxt = c_ST_IDLE;
        end
    end

    // Prefix timer: counts idle cycles only while a prefix is pending
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timer <= '0;
        end else if (in_valid || (w_state_nxt == c_ST_IDLE)) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + c_TMR_W'(1);
        end
    end

    // Held-key tracking, press counting and single-cycle event/error pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_key_code  <= 8'h00;
            r_key_ext   <= 1'b0;
            r_key_down  <= 1'b0;
            r_press_cnt <= '0;
            r_evt_valid <= 1'b0;
            r_evt_break <= 1'b0;
            r_evt_code  <= 8'h00;
            r_evt_ext   <= 1'b0;
            r_seq_err   <= 1'b0;
        end else begin
            r_evt_valid <= 1'b0;
            r_seq_err   <= w_err;
            if (w_make && !w_repeat) begin
                r_key_code  <= in_data;
                r_key_ext   <= w_ext;
                r_key_down  <= 1'b1;
                r_press_cnt <= r_press_cnt + CNT_W'(1);
                r_evt_valid <= 1'b1;
                r_evt_break <= 1'b0;
                r_evt_code  <= in_data;
                r_evt_ext   <= w_ext;
            end else if (w_break) begin
                r_evt_valid <= 1'b1;
                r_evt_break <= 1'b1;
                r_evt_code  <= in_data;
                r_evt_ext   <= w_ext;
                // Releasing some other key leaves the held key alone
                if (w_same_key) begin
                    r_key_down <= 1'b0;
                end
            end
        end
    end

    assign key_code  = r_key_code;
    assign key_ext   = r_key_ext;
    assign key_down  = r_key_down;
    assign press_cnt = r_press_cnt;
    assign evt_valid = r_evt_valid;
    assign evt_break = r_evt_break;
    assign evt_code  = r_evt_code;
    assign evt_ext   = r_evt_ext;
    assign seq_err   = r_seq_err;

endmodule : ps2_key_tracker
`default_nettype wire
